decode_stage: RTL

Instruction Decode stage of the 5-stage RV32I core, directly downstream of instruction fetch. Consumes the IF/ID buffer (valid, instruction, PC), decodes RV32I, reads the register file, detects load-use and control hazards, and drives the stall and PC-select signals back to fetch. Results are registered into the ID/EX pipeline buffer feeding the ALU stage.

---
 rtl/decode_stage_pkg.sv | 76 +++++++
 rtl/decode_stage_regfile.sv | 41 ++++
 rtl/decode_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared types and constants for the ID stage of the RV32I core.
// Latency: n/a (types, opcode constants and a pure decode helper only).
// Backpressure: n/a.
package decode_stage_pkg;

    // Fetch next-PC source: sequential PC or the target resolved in EX.
    typedef enum logic {
        NEXTPC     = 1'b0,
        ALU_RESULT = 1'b1
    } pc_mux;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_t;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RUN,
        WAIT_TARGET,
        FLUSH
    } id_state_t;

    // ID/EX pipeline buffer contents.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        ctrl_xfer;
        logic        illegal;
    } idex_t;

    // funct3/funct7[5] to ALU op. SUB only exists in the register form;
    // for shifts-right bit 30 selects arithmetic in both forms.
    function automatic alu_op_t alu_op_from_funct(input logic [2:0] funct3,
                                                  input logic       bit30,
                                                  input logic       is_reg);
        case (funct3)
            3'b000:  return (is_reg && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// regfile: 32x32 integer register file, x0 hardwired to zero, cleared on reset.
// Latency: reads are combinational; writes land on the rising clock edge.
// Backpressure: none; the write port is always accepted.
// Ports: clock, reset (async active-low), we/waddr/wdata write port, raddr1/2 -> rdata1/2.
// Config: ID_WB_BYPASS_EN defined forwards a same-cycle write to matching reads;
//         undefined, a read returns the pre-write value.
module regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef ID_WB_BYPASS_EN
    assign rdata1 = (raddr1 == 5'd0) ? '0 :
                    (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 :
                    (we && (waddr == raddr2)) ? wdata : regs[raddr2];
`else
    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
`endif

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode, register read, load-use/control hazard handling, issue into ID/EX.
// Latency: one cycle IF/ID -> ID/EX; stall_op and pc_mux_op are combinational.
// Backpressure: ex_stall_ip holds ID/EX and raises stall_op; a load-use hazard raises stall_op one cycle and issues a bubble.
// Ports: clock/reset (async active-low); IF/ID instr_valid_ip/instr_data_ip/instr_pc_addr_ip;
//        EX feedback alu_result_ip/alu_result_valid_ip/ex_stall_ip; WB wb_en_ip/wb_rd_ip/wb_data_ip;
//        to fetch pc_mux_op/stall_op; ID/EX buffer ex_*_op. Macro ID_WB_BYPASS_EN selects regfile bypass.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid_ip,
    input  logic [31:0] instr_data_ip,
    input  logic [31:0] instr_pc_addr_ip,
    input  logic [31:0] alu_result_ip,
    input  logic        alu_result_valid_ip,
    input  logic        ex_stall_ip,
    input  logic        wb_en_ip,
    input  logic [4:0]  wb_rd_ip,
    input  logic [31:0] wb_data_ip,
    output pc_mux       pc_mux_op,
    output logic        stall_op,
    output logic        ex_valid_op,
    output logic [31:0] ex_pc_op,
    output logic [31:0] ex_rs1_data_op,
    output logic [31:0] ex_rs2_data_op,
    output logic [31:0] ex_imm_op,
    output logic [4:0]  ex_rd_op,
    output alu_op_t     ex_alu_op_op,
    output logic        ex_alu_src_imm_op,
    output logic        ex_mem_read_op,
    output logic        ex_mem_write_op,
    output logic        ex_reg_write_op,
    output logic        ex_ctrl_xfer_op,
    output logic        ex_illegal_op
);

    // The resolved target itself is consumed by fetch; decode only needs its valid.
    logic unused_alu_result;
    assign unused_alu_result = ^alu_result_ip;

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic        uses_rs1, uses_rs2, load_use, stall_c;
    idex_t       dec, bubble, idex_d, idex_q;
    id_state_t   state_q, state_d;

    assign ins    = instr_data_ip;
    assign opcode = ins[6:0];
    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {ins[31:12], 12'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    regfile u_regfile (
        .clock  (clock),
        .reset  (reset),
        .we     (wb_en_ip),
        .waddr  (wb_rd_ip),
        .wdata  (wb_data_ip),
        .raddr1 (ins[19:15]),
        .raddr2 (ins[24:20]),
        .rdata1 (rs1_rdata),
        .rdata2 (rs2_rdata)
    );

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = instr_pc_addr_ip;
        dec.rs1_data = rs1_rdata;
        dec.rs2_data = rs2_rdata;
        dec.rd       = ins[11:7];
        dec.alu_op   = ALU_ADD;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        case (opcode)
            OP: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_op_from_funct(ins[14:12], ins[30], 1'b1);
            end
            OP_IMM: begin
                uses_rs1 = 1'b1;
                dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_i;
                dec.alu_op    = alu_op_from_funct(ins[14:12], ins[30], 1'b0);
            end
            LOAD: begin
                uses_rs1 = 1'b1;
                dec.mem_read = 1'b1; dec.reg_write = 1'b1;
                dec.alu_src_imm = 1'b1; dec.imm = imm_i;
            end
            STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
                dec.imm = imm_s; dec.rd = '0;
            end
            BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.ctrl_xfer = 1'b1; dec.imm = imm_b; dec.rd = '0;
            end
            JAL: begin
                dec.ctrl_xfer = 1'b1; dec.reg_write = 1'b1;
                dec.alu_src_imm = 1'b1; dec.imm = imm_j;
            end
            JALR: begin
                uses_rs1 = 1'b1;
                dec.ctrl_xfer = 1'b1; dec.reg_write = 1'b1;
                dec.alu_src_imm = 1'b1; dec.imm = imm_i;
            end
            LUI: begin
                dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
                dec.imm = imm_u; dec.alu_op = ALU_PASS_B;
            end
            AUIPC: begin
                dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_u;
            end
            default: begin
                // Unknown opcode travels down as a non-writing bubble carrying the flag.
                dec.valid = 1'b0; dec.illegal = 1'b1; dec.rd = '0;
            end
        endcase
    end

    assign load_use = instr_valid_ip && idex_q.valid && idex_q.mem_read &&
                      (idex_q.rd != 5'd0) &&
                      ((uses_rs1 && (ins[19:15] == idex_q.rd)) ||
                       (uses_rs2 && (ins[24:20] == idex_q.rd)));

    always_comb begin
        state_d    = state_q;
        idex_d     = idex_q;
        stall_c    = 1'b0;
        pc_mux_op  = NEXTPC;
        bubble     = '0;
        bubble.pc  = instr_pc_addr_ip;
        case (state_q)
            RUN: begin
                if (ex_stall_ip) begin
                    stall_c = 1'b1;
                end else if (load_use) begin
                    stall_c = 1'b1;
                    idex_d  = bubble;
                end else if (!instr_valid_ip) begin
                    idex_d  = bubble;
                end else begin
                    idex_d  = dec;
                    if (dec.ctrl_xfer) state_d = WAIT_TARGET;
                end
            end
            WAIT_TARGET: begin
                pc_mux_op = ALU_RESULT;
                if (ex_stall_ip) stall_c = 1'b1;
                else             idex_d  = bubble;
                // The target can resolve even while EX holds ID/EX.
                if (alu_result_valid_ip) state_d = FLUSH;
            end
            FLUSH: begin
                if (ex_stall_ip) begin
                    stall_c = 1'b1;
                end else begin
                    idex_d  = bubble;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Gated so fetch sees no stall while reset is asserted, whatever EX drives.
    assign stall_op = stall_c & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            idex_q    <= '0;
            idex_q.pc <= RESET_PC;
        end else begin
            state_q   <= state_d;
            idex_q    <= idex_d;
        end
    end

    assign ex_valid_op       = idex_q.valid;
    assign ex_pc_op          = idex_q.pc;
    assign ex_rs1_data_op    = idex_q.rs1_data;
    assign ex_rs2_data_op    = idex_q.rs2_data;
    assign ex_imm_op         = idex_q.imm;
    assign ex_rd_op          = idex_q.rd;
    assign ex_alu_op_op      = idex_q.alu_op;
    assign ex_alu_src_imm_op = idex_q.alu_src_imm;
    assign ex_mem_read_op    = idex_q.mem_read;
    assign ex_mem_write_op   = idex_q.mem_write;
    assign ex_reg_write_op   = idex_q.reg_write;
    assign ex_ctrl_xfer_op   = idex_q.ctrl_xfer;
    assign ex_illegal_op     = idex_q.illegal;

endmodule
